wash_cycle_scheduler: RTL and testbench

Phase-timing and motor scheduler that sits beside Controller.
- Watches Controller's one-hot state and loads a per-phase duration from the selected wash program.
- Counts that duration down in prescaled ticks, then returns a one-cycle phase_done to Controller to advance the FSM.
- Drives motor enable/direction: agitation during WASH and RINSE, fixed direction during SPIN.

---
 rtl/wash_pkg.sv | 77 +++++++
 rtl/wash_cycle_scheduler_if.sv | 35 +++
 rtl/tick_prescaler.sv | 42 ++++
 rtl/wash_cycle_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_wash_cycle_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wash_pkg.sv
// Definitions shared by the wash Controller and its phase scheduler: one-hot
// controller states, program codes, scheduler states and the phase-duration table.
package wash_pkg;

    localparam logic [8:0] ST_IDLE     = 9'b0_0000_0001;
    localparam logic [8:0] ST_READY    = 9'b0_0000_0010;
    localparam logic [8:0] ST_FILL     = 9'b0_0000_0100;
    localparam logic [8:0] ST_WASH     = 9'b0_0000_1000;
    localparam logic [8:0] ST_RINSE    = 9'b0_0001_0000;
    localparam logic [8:0] ST_SPIN     = 9'b0_0010_0000;
    localparam logic [8:0] ST_DRAIN    = 9'b0_0100_0000;
    localparam logic [8:0] ST_COMPLETE = 9'b0_1000_0000;
    localparam logic [8:0] ST_ERROR    = 9'b1_0000_0000;

    localparam logic [8:0] TIMED_MASK = ~(ST_IDLE | ST_READY | ST_COMPLETE | ST_ERROR);

    // Widest entry in the duration table is 16 ticks.
    localparam int DUR_W = 5;

    typedef enum logic [1:0] {
        PROG_NORMAL = 2'd0,
        PROG_QUICK  = 2'd1,
        PROG_HEAVY  = 2'd2,
        PROG_RSVD   = 2'd3
    } prog_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    function automatic logic is_onehot9(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    // Reserved program code falls through to the normal column.
    function automatic logic [DUR_W-1:0] phase_ticks(input prog_e prog, input logic [8:0] st);
        logic [DUR_W-1:0] t;
        t = 5'd0;
        case (prog)
            PROG_QUICK: begin
                case (st)
                    ST_FILL:  t = 5'd2;
                    ST_WASH:  t = 5'd5;
                    ST_RINSE: t = 5'd3;
                    ST_SPIN:  t = 5'd3;
                    ST_DRAIN: t = 5'd2;
                    default:  t = 5'd0;
                endcase
            end
            PROG_HEAVY: begin
                case (st)
                    ST_FILL:  t = 5'd6;
                    ST_WASH:  t = 5'd16;
                    ST_RINSE: t = 5'd8;
                    ST_SPIN:  t = 5'd8;
                    ST_DRAIN: t = 5'd4;
                    default:  t = 5'd0;
                endcase
            end
            default: begin
                case (st)
                    ST_FILL:  t = 5'd4;
                    ST_WASH:  t = 5'd10;
                    ST_RINSE: t = 5'd6;
                    ST_SPIN:  t = 5'd5;
                    ST_DRAIN: t = 5'd3;
                    default:  t = 5'd0;
                endcase
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/wash_cycle_scheduler_if.sv
// Controller <-> scheduler signal bundle. motor_speed is present only when
// SCHED_SPIN_RAMP_EN is defined.
interface wash_cycle_scheduler_if #(
    parameter int COUNT_W = 8
);
    logic [8:0]         state_in;
    logic [1:0]         program_sel;
    logic               pause;
    logic               phase_done;
    logic [COUNT_W-1:0] time_remaining;
    logic               motor_en;
    logic               motor_dir;
    logic               onehot_err;
`ifdef SCHED_SPIN_RAMP_EN
    logic [1:0]         motor_speed;

    modport master (
        output state_in, program_sel, pause,
        input  phase_done, time_remaining, motor_en, motor_dir, onehot_err, motor_speed
    );
    modport slave (
        input  state_in, program_sel, pause,
        output phase_done, time_remaining, motor_en, motor_dir, onehot_err, motor_speed
    );
`else
    modport master (
        output state_in, program_sel, pause,
        input  phase_done, time_remaining, motor_en, motor_dir, onehot_err
    );
    modport slave (
        input  state_in, program_sel, pause,
        output phase_done, time_remaining, motor_en, motor_dir, onehot_err
    );
`endif
endinterface

// File: rtl/tick_prescaler.sv
// Clock prescaler for the wash scheduler: tick_o pulses on every TICK_DIV-th
// enabled clock; clr_i restarts the count from zero.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: clear wins, then wrap on the tick clock, else advance when enabled.
    always_comb begin
        if (clr_i) begin
            cnt_d = {PW{1'b0}};
        end else if (tick_o) begin
            cnt_d = {PW{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + PW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= {PW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_cycle_scheduler.sv
// Phase timer and motor scheduler beside the wash Controller. Optional SPIN speed
// ramp output motor_speed is built when SCHED_SPIN_RAMP_EN is defined.
module wash_cycle_scheduler
    import wash_pkg::*;
#(
    parameter int TICK_DIV      = 4,
    parameter int COUNT_W       = 8,
    parameter int AGITATE_TICKS = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    wash_cycle_scheduler_if.slave  bus
);
    localparam int AGW = (AGITATE_TICKS > 1) ? $clog2(AGITATE_TICKS) : 1;
    localparam logic [AGW-1:0] AG_LAST = AGW'(AGITATE_TICKS - 1);

    if (COUNT_W < DUR_W) begin : g_count_w_check
        $error("COUNT_W is narrower than the phase duration table");
    end
    if ((TICK_DIV < 1) || (AGITATE_TICKS < 1)) begin : g_param_check
        $error("TICK_DIV and AGITATE_TICKS must be at least 1");
    end

    sched_state_e       fsm_q, fsm_d;
    prog_e              prog_q;
    logic [8:0]         state_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [AGW-1:0]     agit_q, agit_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               motor_en_q, motor_en_d;
    logic               motor_dir_q, motor_dir_d;
    logic               err_q, err_d;

    logic legal_s, timed_s, change_s, agit_phase_s, spin_s;
    logic pre_clr_s, pre_en_s, tick_s;

    assign legal_s      = is_onehot9(bus.state_in);
    assign timed_s      = legal_s && ((bus.state_in & TIMED_MASK) != 9'd0);
    assign change_s     = (bus.state_in != state_q);
    assign agit_phase_s = (bus.state_in == ST_WASH) || (bus.state_in == ST_RINSE);
    assign spin_s       = (bus.state_in == ST_SPIN);
    assign pre_clr_s    = !timed_s || change_s;
    assign pre_en_s     = ((fsm_q == S_RUN) || (fsm_q == S_PAUSE)) && !bus.pause && !pre_clr_s;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (pre_clr_s),
        .en_i   (pre_en_s),
        .tick_o (tick_s)
    );

`ifdef SCHED_SPIN_RAMP_EN
    logic [1:0] ramp_q, ramp_d;
    logic [1:0] speed_q, speed_d;
`endif

    // Next-state logic; priority is phase change, then pause, then tick.
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        agit_d = agit_q;
        dir_d  = dir_q;
        done_d = 1'b0;
`ifdef SCHED_SPIN_RAMP_EN
        ramp_d = ramp_q;
`endif
        if (!timed_s) begin
            fsm_d  = S_IDLE;
            cnt_d  = {COUNT_W{1'b0}};
            agit_d = {AGW{1'b0}};
            dir_d  = 1'b0;
        end else if (change_s) begin
            fsm_d  = ((fsm_q == S_PAUSE) && bus.pause) ? S_PAUSE : S_RUN;
            cnt_d  = COUNT_W'(phase_ticks(prog_q, bus.state_in));
            agit_d = {AGW{1'b0}};
            dir_d  = 1'b0;
`ifdef SCHED_SPIN_RAMP_EN
            ramp_d = 2'd1;
`endif
        end else begin
            case (fsm_q)
                S_RUN, S_PAUSE: begin
                    if (bus.pause) begin
                        fsm_d = S_PAUSE;
                    end else if (cnt_q == {COUNT_W{1'b0}}) begin
                        fsm_d  = S_DONE;
                        done_d = 1'b1;
                    end else if (tick_s) begin
                        cnt_d = cnt_q - COUNT_W'(1);
                        if (cnt_q == COUNT_W'(1)) begin
                            fsm_d  = S_DONE;
                            done_d = 1'b1;
                        end else begin
                            fsm_d = S_RUN;
                            if (agit_phase_s && (agit_q == AG_LAST)) begin
                                agit_d = {AGW{1'b0}};
                                dir_d  = ~dir_q;
                            end else if (agit_phase_s) begin
                                agit_d = agit_q + AGW'(1);
                            end else begin
                                agit_d = agit_q;
                            end
`ifdef SCHED_SPIN_RAMP_EN
                            if (ramp_q != 2'd3) begin
                                ramp_d = ramp_q + 2'd1;
                            end else begin
                                ramp_d = ramp_q;
                            end
`endif
                        end
                    end else begin
                        fsm_d = S_RUN;
                    end
                end
                S_DONE: begin
                    cnt_d = {COUNT_W{1'b0}};
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end

        motor_en_d  = (fsm_d == S_RUN) && (agit_phase_s || spin_s);
        motor_dir_d = (fsm_d == S_RUN) && agit_phase_s && dir_d;
        err_d       = !legal_s;
`ifdef SCHED_SPIN_RAMP_EN
        if (spin_s && ((fsm_d == S_RUN) || (fsm_d == S_PAUSE))) begin
            speed_d = ramp_d;
        end else if (spin_s) begin
            speed_d = 2'd0;
        end else begin
            speed_d = {1'b0, motor_en_d};
        end
`endif
    end

    // Scheduler state, program latch and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q       <= S_IDLE;
            prog_q      <= PROG_NORMAL;
            state_q     <= 9'd0;
            cnt_q       <= {COUNT_W{1'b0}};
            agit_q      <= {AGW{1'b0}};
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            motor_en_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef SCHED_SPIN_RAMP_EN
            ramp_q      <= 2'd0;
            speed_q     <= 2'd0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= bus.state_in;
            cnt_q       <= cnt_d;
            agit_q      <= agit_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            motor_en_q  <= motor_en_d;
            motor_dir_q <= motor_dir_d;
            err_q       <= err_d;
            if (bus.state_in == ST_READY) begin
                prog_q <= prog_e'(bus.program_sel);
            end else begin
                prog_q <= prog_q;
            end
`ifdef SCHED_SPIN_RAMP_EN
            ramp_q      <= ramp_d;
            speed_q     <= speed_d;
`endif
        end
    end

    assign bus.phase_done     = done_q;
    assign bus.time_remaining = cnt_q;
    assign bus.motor_en       = motor_en_q;
    assign bus.motor_dir      = motor_dir_q;
    assign bus.onehot_err     = err_q;
`ifdef SCHED_SPIN_RAMP_EN
    assign bus.motor_speed    = speed_q;
`endif

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// Self-checking bench for wash_cycle_scheduler: directed vector table, multi-cycle
// corner sequences and a randomized run against an arithmetic reference model.
module tb_wash_cycle_scheduler;

    localparam int TICK = 4;
    localparam int AG   = 3;
    localparam int CW   = 8;

    localparam logic [8:0] ST_IDLE  = 9'h001;
    localparam logic [8:0] ST_READY = 9'h002;
    localparam logic [8:0] ST_FILL  = 9'h004;
    localparam logic [8:0] ST_WASH  = 9'h008;
    localparam logic [8:0] ST_RINSE = 9'h010;
    localparam logic [8:0] ST_SPIN  = 9'h020;
    localparam logic [8:0] ST_DRAIN = 9'h040;
    localparam logic [8:0] ST_ERROR = 9'h100;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    typedef struct packed {
        logic [8:0] st;
        logic [1:0] pg;
        logic       pz;
        logic [7:0] n;
        logic [7:0] rem;
        logic       en;
        logic       dir;
        logic       done;
        logic       err;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;

    vec_t vecs [0:16];

    // reference model state
    logic [8:0] m_prev;
    logic [1:0] m_prog;
    int         m_mode, m_act, m_dur;
    int         e_rem;
    logic       e_done, e_en, e_dir, e_err;

    // scratch for the directed and random sequences
    int         c, pulses, first_at, hold;
    logic [8:0] cur_st;
    logic       cur_pz;

    wash_cycle_scheduler_if #(.COUNT_W(CW)) bus ();

    wash_cycle_scheduler #(
        .TICK_DIV      (TICK),
        .COUNT_W       (CW),
        .AGITATE_TICKS (AG)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int rem, input logic en, input logic dir,
                           input logic done, input logic err);
        chk({nm, ".time_remaining"}, 32'(bus.time_remaining), 32'(rem));
        chk({nm, ".motor_en"},       32'(bus.motor_en),       32'(en));
        chk({nm, ".motor_dir"},      32'(bus.motor_dir),      32'(dir));
        chk({nm, ".phase_done"},     32'(bus.phase_done),     32'(done));
        chk({nm, ".onehot_err"},     32'(bus.onehot_err),     32'(err));
    endtask

    function automatic int dur_of(input logic [1:0] pg, input logic [8:0] st);
        int row [5];
        case (pg)
            2'd1:    row = '{2, 5, 3, 3, 2};
            2'd2:    row = '{6, 16, 8, 8, 4};
            default: row = '{4, 10, 6, 5, 3};
        endcase
        for (int i = 0; i < 5; i++) begin
            if (st[i + 2]) return row[i];
        end
        return 0;
    endfunction

    // Model in terms of unpaused clocks elapsed since phase entry.
    task automatic model_step(input logic [8:0] st, input logic [1:0] ps, input logic pz);
        logic legal, timed, agit;
        legal  = ($countones(st) == 1);
        timed  = legal && (st[2] || st[3] || st[4] || st[5] || st[6]);
        agit   = (st == ST_WASH) || (st == ST_RINSE);
        e_err  = !legal;
        e_done = 1'b0;
        if (!timed) begin
            m_mode = M_IDLE;
            m_act  = 0;
            m_dur  = 0;
        end else if (st != m_prev) begin
            m_mode = (m_mode == M_PAUSE && pz) ? M_PAUSE : M_RUN;
            m_dur  = dur_of(m_prog, st);
            m_act  = 0;
        end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
            if (pz) begin
                m_mode = M_PAUSE;
            end else begin
                m_act++;
                m_mode = M_RUN;
                if (m_act >= m_dur * TICK) begin
                    m_mode = M_DONE;
                    e_done = 1'b1;
                end
            end
        end
        e_rem = (m_mode == M_RUN || m_mode == M_PAUSE) ? (m_dur - m_act / TICK) : 0;
        e_en  = (m_mode == M_RUN) && (agit || st == ST_SPIN);
        e_dir = e_en && agit && (((m_act / TICK) / AG) % 2 == 1);
        if (st == ST_READY) m_prog = ps;
        m_prev = st;
    endtask

    initial begin
        //           st        pg    pz    n      rem   en    dir   done  err
        vecs[0]  = '{ST_IDLE,  2'd0, 1'b0, 8'd2,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{ST_READY, 2'd0, 1'b0, 8'd2,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{ST_FILL,  2'd0, 1'b0, 8'd1,  8'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{ST_FILL,  2'd0, 1'b0, 8'd4,  8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{ST_FILL,  2'd0, 1'b0, 8'd4,  8'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ST_FILL,  2'd0, 1'b0, 8'd4,  8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{ST_FILL,  2'd0, 1'b0, 8'd3,  8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ST_FILL,  2'd0, 1'b0, 8'd1,  8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{ST_FILL,  2'd0, 1'b0, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{ST_READY, 2'd1, 1'b0, 8'd2,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{ST_WASH,  2'd2, 1'b0, 8'd1,  8'd5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{ST_WASH,  2'd2, 1'b0, 8'd12, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{ST_WASH,  2'd2, 1'b0, 8'd7,  8'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{ST_WASH,  2'd2, 1'b0, 8'd1,  8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{ST_ERROR, 2'd0, 1'b0, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{9'h006,   2'd0, 1'b0, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{ST_IDLE,  2'd0, 1'b0, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.state_in    = ST_IDLE;
        bus.program_sel = 2'd0;
        bus.pause       = 1'b0;
        reset           = 1'b0;
        #12;
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus.state_in    = vecs[i].st;
            bus.program_sel = vecs[i].pg;
            bus.pause       = vecs[i].pz;
            repeat (int'(vecs[i].n)) step();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].rem), vecs[i].en, vecs[i].dir,
                    vecs[i].done, vecs[i].err);
        end

        // RINSE (normal, 24 clocks) with a 7-clock pause after 5 running clocks
        bus.state_in = ST_READY; bus.program_sel = 2'd0;
        repeat (2) step();
        bus.state_in = ST_RINSE;
        step();
        repeat (5) step();
        chk("pause.pre_motor_en", 32'(bus.motor_en), 32'd1);
        bus.pause = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("pause.motor_en", 32'(bus.motor_en), 32'd0);
        end
        bus.pause = 1'b0;
        c = 12;
        while (!bus.phase_done && c < 100) begin
            step();
            c++;
        end
        chk("pause.done_clock", 32'(c), 32'd31);

        // WASH abandoned for ERROR part-way through the count
        bus.state_in = ST_READY;
        repeat (2) step();
        bus.state_in = ST_WASH;
        step();
        repeat (10) step();
        chk("abort.mid_remaining", 32'(bus.time_remaining), 32'd8);
        bus.state_in = ST_ERROR;
        step();
        chk_all("abort", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        repeat (5) begin
            step();
            if (bus.phase_done) pulses++;
        end
        chk("abort.no_done", 32'(pulses), 32'd0);

        // DRAIN held 30 clocks past expiry: a single pulse at clock 12
        bus.state_in = ST_READY;
        repeat (2) step();
        bus.state_in = ST_DRAIN;
        step();
        pulses = 0; first_at = -1;
        for (int k = 1; k <= 42; k++) begin
            step();
            if (bus.phase_done) begin
                pulses++;
                first_at = k;
            end
        end
        chk("linger.pulses", 32'(pulses), 32'd1);
        chk("linger.pulse_clock", 32'(first_at), 32'd12);

        // SPIN (quick) then asynchronous reset between clock edges
        bus.state_in = ST_READY; bus.program_sel = 2'd1;
        repeat (2) step();
        bus.state_in = ST_SPIN;
        step();
        repeat (6) step();
        chk_all("spin", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // randomized run against the reference model
        bus.state_in = ST_IDLE; bus.program_sel = 2'd0; bus.pause = 1'b0;
        m_prev = 9'd0; m_prog = 2'd0; m_mode = M_IDLE; m_act = 0; m_dur = 0;
        cur_st = ST_IDLE; cur_pz = 1'b0; hold = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) == 0) cur_st = 9'($urandom_range(0, 511));
                else cur_st = 9'd1 << $urandom_range(0, 8);
                hold = $urandom_range(1, 60);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) cur_pz = ~cur_pz;
            bus.state_in    = cur_st;
            bus.program_sel = 2'($urandom_range(0, 3));
            bus.pause       = cur_pz;
            model_step(cur_st, bus.program_sel, cur_pz);
            step();
            chk_all($sformatf("rand%0d", cyc), e_rem, e_en, e_dir, e_done, e_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
